nzcv_flag_unit: RTL and testbench

- Producer side of the condition-flag interface: computes NZCV for flag-setting instructions (ADDS/SUBS/ANDS/flag write) in EX, holds them in a pending stage, then commits them to the architectural NZCV register.
- Drives the zero/negative/carry/overflow inputs of the branch-condition checker with the newest in-flight flags. Stall and flush inputs come from the pipeline hazard/control logic.

---
 rtl/nzcv_flag_unit.sv | 131 +++++++++++++
 tb/tb_nzcv_flag_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/nzcv_flag_unit.sv
// NZCV producer: computes flags in EX, holds them in a pending stage, commits to arch NZCV.
// Optional FLAG_FWD_EN: when defined, outputs forward pending flags instead of raising flag_hazard.
module nzcv_flag_unit #(
   parameter int unsigned DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              set_flags,
   input  logic [1:0]        flag_op,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic [3:0]        flag_in,
   output logic              zero,
   output logic              negative,
   output logic              carry,
   output logic              overflow,
   output logic              flag_hazard
);

   typedef enum logic [1:0] {
      OpAdd    = 2'b00,
      OpSub    = 2'b01,
      OpLogic  = 2'b10,
      OpDirect = 2'b11
   } flag_op_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } nzcv_t;

   localparam int unsigned Msb = DATA_W - 1;

   flag_op_e          op;
   logic              is_sub;
   logic [DATA_W-1:0] b_eff;
   logic [DATA_W:0]   sum_ext;
   logic [DATA_W-1:0] result;
   nzcv_t             flags_calc;

   nzcv_t arch_q, arch_d;
   nzcv_t pend_q, pend_d;
   logic  pend_valid_q, pend_valid_d;
   nzcv_t view;

   assign op     = flag_op_e'(flag_op);
   assign is_sub = (op == OpSub);
   assign b_eff  = is_sub ? ~op_b : op_b;

   // One adder serves ADD and SUB; SUB is a + ~b + 1, so carry-out means "no borrow".
   assign sum_ext = {1'b0, op_a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};

   always_comb begin
      result     = sum_ext[DATA_W-1:0];
      flags_calc = '0;
      unique case (op)
         OpAdd: begin
            result       = sum_ext[DATA_W-1:0];
            flags_calc.c = sum_ext[DATA_W];
            flags_calc.v = (op_a[Msb] == op_b[Msb]) && (result[Msb] != op_a[Msb]);
         end
         OpSub: begin
            result       = sum_ext[DATA_W-1:0];
            flags_calc.c = sum_ext[DATA_W];
            flags_calc.v = (op_a[Msb] != op_b[Msb]) && (result[Msb] != op_a[Msb]);
         end
         OpLogic: begin
            result       = op_a & op_b;
            flags_calc.c = 1'b0;
            flags_calc.v = 1'b0;
         end
         OpDirect: begin
            result = '0;
         end
      endcase
      if (op == OpDirect) begin
         flags_calc = nzcv_t'(flag_in);
      end else begin
         flags_calc.n = result[Msb];
         flags_calc.z = (result == '0);
      end
   end

   // Commit of entry k and capture of entry k+1 share an edge; stall freezes both stages.
   always_comb begin
      arch_d       = arch_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      if (!stall) begin
         if (pend_valid_q) begin
            arch_d = pend_q;
         end
         if (set_flags && !flush) begin
            pend_d       = flags_calc;
            pend_valid_d = 1'b1;
         end else begin
            pend_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         arch_q       <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
      end else begin
         arch_q       <= arch_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
      end
   end

`ifdef FLAG_FWD_EN
   assign view        = pend_valid_q ? pend_q : arch_q;
   assign flag_hazard = 1'b0;
`else
   assign view        = arch_q;
   assign flag_hazard = pend_valid_q;
`endif

   assign negative = view.n;
   assign zero     = view.z;
   assign carry    = view.c;
   assign overflow = view.v;

endmodule

// File: tb/tb_nzcv_flag_unit.sv
// Self-checking bench for nzcv_flag_unit: directed cases from the flag rules plus random traffic
// checked against a behavioural model (flags from plain wide arithmetic, two-slot pipeline model).
module tb_nzcv_flag_unit;

   localparam int unsigned W = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic         stall;
   logic         flush;
   logic         set_flags;
   logic [1:0]   flag_op;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic [3:0]   flag_in;
   logic         zero;
   logic         negative;
   logic         carry;
   logic         overflow;
   logic         flag_hazard;

   int unsigned tests_run    = 0;
   int unsigned tests_failed = 0;

   // Model state: committed flags and the in-flight (pending) entry.
   logic [3:0] m_arch;
   logic [3:0] m_pend;
   bit         m_pv;

   nzcv_flag_unit #(
      .DATA_W (W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .flush       (flush),
      .set_flags   (set_flags),
      .flag_op     (flag_op),
      .op_a        (op_a),
      .op_b        (op_b),
      .flag_in     (flag_in),
      .zero        (zero),
      .negative    (negative),
      .carry       (carry),
      .overflow    (overflow),
      .flag_hazard (flag_hazard)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [4:0] observed, input logic [4:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("FAIL %s: got hazard/NZCV=%b required %b at %0t", tag, observed, expected, $time);
      end
   endtask

   // Flags from the arithmetic definitions: unsigned wide sum for C, signed wide sum for V.
   function automatic logic [3:0] ref_flags(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [3:0] fin);
      logic [W:0]        u;
      logic signed [W:0] s;
      logic [W-1:0]      r;
      logic              c;
      logic              v;
      case (op)
         2'b00: begin
            u = {1'b0, a} + {1'b0, b};
            s = $signed({a[W-1], a}) + $signed({b[W-1], b});
            r = a + b;
            c = u[W];
            v = (s[W] != s[W-1]);
         end
         2'b01: begin
            s = $signed({a[W-1], a}) - $signed({b[W-1], b});
            r = a - b;
            c = (a >= b);
            v = (s[W] != s[W-1]);
         end
         2'b10: begin
            r = a & b;
            c = 1'b0;
            v = 1'b0;
         end
         default: return fin;
      endcase
      return {r[W-1], (r == '0), c, v};
   endfunction

   function automatic logic [4:0] exp_view();
`ifdef FLAG_FWD_EN
      return {1'b0, (m_pv ? m_pend : m_arch)};
`else
      return {m_pv, m_arch};
`endif
   endfunction

   function automatic logic [4:0] dut_view();
      return {flag_hazard, negative, zero, carry, overflow};
   endfunction

   // Drive one cycle of inputs, advance the model across the edge, check on the falling edge.
   task automatic step(input bit sf, input bit fl, input bit st, input logic [1:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] fin);
      set_flags = sf;
      flush     = fl;
      stall     = st;
      flag_op   = op;
      op_a      = a;
      op_b      = b;
      flag_in   = fin;
      @(posedge clk);
      if (!st) begin
         if (m_pv) m_arch = m_pend;
         if (sf && !fl) begin
            m_pend = ref_flags(op, a, b, fin);
            m_pv   = 1'b1;
         end else begin
            m_pv = 1'b0;
         end
      end
      @(negedge clk);
      check("cycle", dut_view(), exp_view());
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, 4'b0000);
   endtask

   initial begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [1:0]   op;

      reset     = 1'b1;
      stall     = 1'b0;
      flush     = 1'b0;
      set_flags = 1'b0;
      flag_op   = 2'b00;
      op_a      = '0;
      op_b      = '0;
      flag_in   = 4'b0000;
      m_arch    = 4'b0000;
      m_pend    = 4'b0000;
      m_pv      = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_state", dut_view(), 5'b00000);
      reset = 1'b0;
      @(negedge clk);
      check("post_reset", dut_view(), 5'b00000);

      // SUBS 5-5: visible next cycle (fwd) or after commit, arch 0110 a cycle later.
      step(1'b1, 1'b0, 1'b0, 2'b01, 64'd5, 64'd5, 4'b0000);
`ifdef FLAG_FWD_EN
      check("subs_eq_fwd", dut_view(), 5'b00110);
`else
      check("subs_eq_hazard", dut_view(), 5'b10000);
`endif
      idle();
      check("subs_eq_arch", dut_view(), 5'b00110);
      idle();
      check("subs_eq_hold", dut_view(), 5'b00110);

      step(1'b1, 1'b0, 1'b0, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0000);
      idle();
      check("adds_ovf", dut_view(), 5'b01001);
      step(1'b1, 1'b0, 1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0000);
      idle();
      check("adds_carry", dut_view(), 5'b00110);

      // Back-to-back setters commit in order.
      step(1'b1, 1'b0, 1'b0, 2'b01, 64'd3, 64'd5, 4'b0000);
      step(1'b1, 1'b0, 1'b0, 2'b10, 64'h0F, 64'hF0, 4'b0000);
`ifdef FLAG_FWD_EN
      check("b2b_second_fwd", dut_view(), 5'b00100);
`else
      check("b2b_first_arch", dut_view(), 5'b11000);
`endif
      idle();
      check("b2b_arch_end", dut_view(), 5'b00100);

      step(1'b1, 1'b1, 1'b0, 2'b01, 64'd5, 64'd5, 4'b0000);
      check("flush_ignored", dut_view(), 5'b00100);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 2'b11, '0, '0, 4'b1111);
      check("stall_hold", dut_view(), 5'b00100);
      step(1'b1, 1'b0, 1'b0, 2'b11, '0, '0, 4'b1011);
      idle();
      check("direct", dut_view(), 5'b01011);

      // Async reset while an entry is pending.
      step(1'b1, 1'b0, 1'b0, 2'b01, 64'd3, 64'd5, 4'b0000);
      set_flags = 1'b0;
      #2 reset = 1'b1;
      #1 check("async_reset", dut_view(), 5'b00000);
      m_arch = 4'b0000;
      m_pend = 4'b0000;
      m_pv   = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      idle();
      check("reset_discard", dut_view(), 5'b00000);

      for (int n = 0; n < 400; n++) begin
         op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: a = W'($urandom_range(0, 8));
            1: a = {1'b0, {(W-1){1'b1}}} - W'($urandom_range(0, 2));
            2: a = {1'b1, {(W-1){1'b0}}} + W'($urandom_range(0, 2));
            default: a = {$urandom, $urandom};
         endcase
         case ($urandom_range(0, 3))
            0: b = W'($urandom_range(0, 8));
            1: b = a;
            2: b = ~W'($urandom_range(0, 2));
            default: b = {$urandom, $urandom};
         endcase
         step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 1),
              ($urandom_range(0, 9) < 2), op, a, b, 4'($urandom_range(0, 15)));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
